// File: rtl/testdata_pkg.sv
// testdata_pkg
//   Shared definitions for the test-data stream buffer:
//   - state_t   : buffer state (LOAD, LOADED, PLAY)
//   - depth_of  : number of RAM entries for a given address width
package testdata_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_LOADED = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    function automatic int unsigned depth_of(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/dist_ram_1w1r.sv
// dist_ram_1w1r
//   Signed distributed RAM, one synchronous write port and one asynchronous
//   read port. Contents are never reset.
//   Ports:
//     clk    in  : write clock, rising edge
//     we     in  : write enable
//     waddr  in  : write address
//     wdata  in  : write data (signed)
//     raddr  in  : read address
//     rdata  out : mem[raddr], combinational
module dist_ram_1w1r
    import testdata_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 4
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_BITS-1:0]         waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_BITS-1:0]         raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = depth_of(ADDR_BITS);

    (* ram_style = "distributed" *)
    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/testdata_stream_buffer.sv
// testdata_stream_buffer
//   Loads signed samples over a valid/ready write stream into a distributed
//   RAM, then on start replays them in order over a valid/ready read stream,
//   once or looped.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     clear             : discard contents, return to LOAD (keeps pass_count)
//     s_data/s_valid/s_last/s_ready : load stream
//     start, loop_en    : playback control
//     m_data/m_valid/m_last/m_ready : playback stream
//     fill_count        : stored samples, 0..DEPTH
//     pass_count        : completed playback passes (wraps)
//     done              : one-cycle pulse when a non-looped playback ends
module testdata_stream_buffer
    import testdata_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 4,
    parameter int PASS_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    input  logic                         start,
    input  logic                         loop_en,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_valid,
    output logic                         m_last,
    input  logic                         m_ready,
    output logic [ADDR_BITS:0]           fill_count,
    output logic [PASS_BITS-1:0]         pass_count,
    output logic                         done
);

    localparam logic [ADDR_BITS:0]   FILL_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    // fill_count value at which the next accepted write fills the RAM
    localparam logic [ADDR_BITS:0]   FILL_LAST = {1'b0, {ADDR_BITS{1'b1}}};
    localparam logic [ADDR_BITS-1:0] PTR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [PASS_BITS-1:0] PASS_ONE  = {{(PASS_BITS-1){1'b0}}, 1'b1};

    state_t               state;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   last_idx;
    logic                 s_fire;
    logic                 m_fire;

    assign s_ready  = (state == ST_LOAD);
    assign m_valid  = (state == ST_PLAY);
    assign last_idx = fill_count - FILL_ONE;
    assign m_last   = m_valid && ({1'b0, rd_ptr} == last_idx);
    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_valid && m_ready;

    // Writes are suppressed under clear/rst so neither can race a load.
    dist_ram_1w1r #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (s_fire && !clear && !rst),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (rd_ptr),
        .rdata (m_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            pass_count <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state      <= ST_LOAD;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_count <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (s_fire) begin
                            wr_ptr     <= wr_ptr + PTR_ONE;
                            fill_count <= fill_count + FILL_ONE;
                            if (s_last || (fill_count == FILL_LAST)) begin
                                state <= ST_LOADED;
                            end
                        end
                    end
                    ST_LOADED: begin
                        if (start && (fill_count != '0)) begin
                            state      <= ST_PLAY;
                            rd_ptr     <= '0;
                            pass_count <= '0;
                        end
                    end
                    ST_PLAY: begin
                        if (m_fire) begin
                            if (!m_last) begin
                                rd_ptr <= rd_ptr + PTR_ONE;
                            end else begin
                                pass_count <= pass_count + PASS_ONE;
                                rd_ptr     <= '0;
                                if (!loop_en) begin
                                    state <= ST_LOADED;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= ST_LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_testdata_stream_buffer.sv
// tb_testdata_stream_buffer
//   Directed bench for testdata_stream_buffer. Expected playback samples are
//   queued when loaded and compared whenever the DUT presents m_valid.
module tb_testdata_stream_buffer;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic               start;
    logic               loop_en;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               m_last;
    logic               m_ready;
    logic [4:0]         fill_count;
    logic [7:0]         pass_count;
    logic               done;

    typedef struct {
        logic signed [15:0] data;
        logic               last;
    } exp_t;

    exp_t               exp_q[$];
    logic signed [15:0] stim[$];
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    testdata_stream_buffer #(
        .DATA_WIDTH (16),
        .ADDR_BITS  (4),
        .PASS_BITS  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .start      (start),
        .loop_en    (loop_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .fill_count (fill_count),
        .pass_count (pass_count),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every entry of stim, one per cycle; s_last on the final one if asked.
    task automatic load_stim(input logic with_last);
        for (int i = 0; i < stim.size(); i++) begin
            s_valid = 1'b1;
            s_data  = stim[i];
            s_last  = with_last && (i == stim.size() - 1);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_stim(input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < stim.size(); i++) begin
                exp_q.push_back('{data: stim[i], last: (i == stim.size() - 1)});
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input logic rnd_ready);
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) break;
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("done_seen", done, 1'b1);
        check("sb_drained", exp_q.size(), 0);
        m_ready = 1'b1;
        tick();
        check("done_one_cycle", done, 1'b0);
    endtask

    // Output monitor: every presented sample must match the scoreboard front,
    // which also proves the sample holds steady while stalled.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_mvalid_low", m_valid, 1'b0);
        end
        if (m_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", m_valid, 1'b0);
            end else begin
                check("m_data", m_data, exp_q[0].data);
                check("m_last", m_last, exp_q[0].last);
                if (m_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        start = 1'b0; loop_en = 1'b0; m_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_fill", fill_count, 0);
        check("rst_pass", pass_count, 0);
        check("rst_done", done, 1'b0);

        // Load five samples and play once with the consumer always ready.
        stim = '{-16'sd3, 16'sd7, 16'sd0, 16'sd32767, -16'sd32768};
        load_stim(1'b1);
        check("load5_s_ready", s_ready, 1'b0);
        check("load5_fill", fill_count, 5);
        push_stim(1);
        pulse_start();
        check("play_first_valid", m_valid, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("play5_done", done, 1'b1);
        check("play5_pass", pass_count, 1);
        tick();
        check("play5_done_low", done, 1'b0);

        // Second start replays the same contents.
        push_stim(1);
        pulse_start();
        wait_done(20, 1'b0);
        check("replay_pass", pass_count, 1);

        // Clear keeps pass_count; then fill the buffer without s_last.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_pass_kept", pass_count, 1);
        check("clear_fill", fill_count, 0);
        stim = {};
        for (int i = 0; i < 16; i++) stim.push_back(16'(i * 1000 - 7000));
        load_stim(1'b0);
        check("full_fill", fill_count, 16);
        check("full_s_ready", s_ready, 1'b0);
        s_valid = 1'b1; s_data = 16'sh7abc;
        tick();
        s_valid = 1'b0;
        check("full_17th_fill", fill_count, 16);
        push_stim(1);
        pulse_start();
        wait_done(40, 1'b0);

        // Clear beats start and m_ready during PLAY; only entry 0 is seen.
        exp_q.push_back('{data: stim[0], last: 1'b0});
        pulse_start();
        clear = 1'b1; start = 1'b1; m_ready = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        check("clr_play_m_valid", m_valid, 1'b0);
        check("clr_play_fill", fill_count, 0);
        check("clr_play_s_ready", s_ready, 1'b1);
        check("clr_play_sb", exp_q.size(), 0);
        pulse_start();
        check("empty_start_m_valid", m_valid, 1'b0);
        check("empty_start_s_ready", s_ready, 1'b1);

        // Backpressure on a four-sample playback.
        stim = '{16'sd11, -16'sd22, 16'sd33, -16'sd44};
        load_stim(1'b1);
        push_stim(1);
        m_ready = 1'b0;
        pulse_start();
        wait_done(200, 1'b1);
        check("bp_pass", pass_count, 1);

        // Looping: two full passes, loop_en dropped mid third pass.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        stim = '{16'sd10, -16'sd20, 16'sd30};
        load_stim(1'b1);
        push_stim(3);
        loop_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 7; i++) tick();
        check("loop_pass_mid", pass_count, 2);
        check("loop_mid_valid", m_valid, 1'b1);
        loop_en = 1'b0;
        wait_done(10, 1'b0);
        check("loop_pass", pass_count, 3);

        // Reset mid-load, then reload a single sample.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_keeps_pass3", pass_count, 3);
        stim = '{16'sd100, 16'sd200};
        load_stim(1'b0);
        check("pre_rst_fill", fill_count, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_fill", fill_count, 0);
        check("mid_rst_pass", pass_count, 0);
        check("mid_rst_s_ready", s_ready, 1'b1);
        stim = '{16'sd555};
        load_stim(1'b1);
        check("reload_fill", fill_count, 1);
        push_stim(1);
        pulse_start();
        wait_done(10, 1'b0);
        check("reload_pass", pass_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
